// File: rtl/dmem_responder.sv
// dmem_responder: tagged read/write requests performed on a local word RAM, answered in order
// through a credit-limited response FIFO. Define DMEM_PARITY_EN to add the rsp_parity output.

// Protocol checker: the credit rule must make FIFO overflow impossible, and a stalled head must hold.
module dmem_responder_chk #(
  parameter int RSP_DEPTH = 4,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 4,
  parameter int CNT_W     = 3
) (
  input logic              clk,
  input logic              rst,
  input logic              i_push,
  input logic              i_pop,
  input logic [CNT_W-1:0]  i_count,
  input logic              i_rsp_valid,
  input logic              i_rsp_ready,
  input logic [DATA_W-1:0] i_rsp_rdata,
  input logic              i_rsp_write,
  input logic [TAG_W-1:0]  i_rsp_tag
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && (i_count == CNT_W'(RSP_DEPTH))));

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    (i_count <= CNT_W'(RSP_DEPTH)));

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (i_rsp_valid && !i_rsp_ready) |=>
      (i_rsp_valid && $stable(i_rsp_rdata) && $stable(i_rsp_write) && $stable(i_rsp_tag)));

endmodule

module dmem_responder #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic [TAG_W-1:0]  rsp_tag,
`ifdef DMEM_PARITY_EN
  output logic              rsp_parity,
`endif
  output logic              busy
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = 1 << ADDR_W;

`ifdef DMEM_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  logic [DATA_W-1:0] r_mem [0:WORDS-1];

  logic              r_s1_valid;
  logic              r_s1_write;
  logic [DATA_W-1:0] r_s1_rdata;
  logic [TAG_W-1:0]  r_s1_tag;

  logic [DATA_W-1:0] r_fifo_rdata [0:RSP_DEPTH-1];
  logic              r_fifo_write [0:RSP_DEPTH-1];
  logic [TAG_W-1:0]  r_fifo_tag   [0:RSP_DEPTH-1];
`ifdef DMEM_PARITY_EN
  logic              r_fifo_par   [0:RSP_DEPTH-1];
`endif
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_outstanding;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] w_ram_rdata;

  // Credits come only from registered occupancy, so a same-cycle pop never frees a slot early.
  always_comb begin
    w_outstanding = r_count + {{(CNT_W-1){1'b0}}, r_s1_valid};
    w_req_ready   = (w_outstanding < CNT_W'(RSP_DEPTH)) && !rst;
    w_accept      = req_valid && w_req_ready;
    w_rsp_valid   = (r_count != {CNT_W{1'b0}});
    w_push        = r_s1_valid;
    w_pop         = w_rsp_valid && rsp_ready;
    w_ram_rdata   = r_mem[req_addr];
  end

  // RAM write on the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (w_accept && req_write) begin
      r_mem[req_addr] <= req_wdata;
    end
  end

  // Access stage: read data (or a zero ack payload) captured on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_write <= 1'b0;
      r_s1_rdata <= {DATA_W{1'b0}};
      r_s1_tag   <= {TAG_W{1'b0}};
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_write <= req_write;
        r_s1_rdata <= req_write ? {DATA_W{1'b0}} : w_ram_rdata;
        r_s1_tag   <= req_tag;
      end
    end
  end

  // FIFO storage: entry written at the tail whenever the access stage holds a response
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rdata[r_wr_ptr] <= r_s1_rdata;
      r_fifo_write[r_wr_ptr] <= r_s1_write;
      r_fifo_tag[r_wr_ptr]   <= r_s1_tag;
`ifdef DMEM_PARITY_EN
      r_fifo_par[r_wr_ptr]   <= even_parity(r_s1_rdata);
`endif
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response outputs come straight from the head entry and read as zero when nothing is queued
  always_comb begin
    req_ready = w_req_ready;
    busy      = (w_outstanding != {CNT_W{1'b0}});
    rsp_valid = w_rsp_valid;
    if (w_rsp_valid) begin
      rsp_rdata = r_fifo_rdata[r_rd_ptr];
      rsp_write = r_fifo_write[r_rd_ptr];
      rsp_tag   = r_fifo_tag[r_rd_ptr];
    end else begin
      rsp_rdata = {DATA_W{1'b0}};
      rsp_write = 1'b0;
      rsp_tag   = {TAG_W{1'b0}};
    end
  end

`ifdef DMEM_PARITY_EN
  // Parity travels with its data word; an empty FIFO reads as zero
  always_comb begin
    if (w_rsp_valid) begin
      rsp_parity = r_fifo_par[r_rd_ptr];
    end else begin
      rsp_parity = 1'b0;
    end
  end
`endif

  dmem_responder_chk #(
    .RSP_DEPTH (RSP_DEPTH),
    .DATA_W    (DATA_W),
    .TAG_W     (TAG_W),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_count     (r_count),
    .i_rsp_valid (w_rsp_valid),
    .i_rsp_ready (rsp_ready),
    .i_rsp_rdata (rsp_rdata),
    .i_rsp_write (rsp_write),
    .i_rsp_tag   (rsp_tag)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a queue-based model.
// Build with DMEM_PARITY_EN defined to also exercise rsp_parity.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_write;
  logic [3:0]  rsp_tag;
  logic        rsp_parity;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_write (rsp_write),
    .rsp_tag   (rsp_tag),
`ifdef DMEM_PARITY_EN
    .rsp_parity(rsp_parity),
`endif
    .busy      (busy)
  );

`ifndef DMEM_PARITY_EN
  assign rsp_parity = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every accepted request becomes one expected response, visible from
  // 'vis' edges onward, removed when consumed. Credits = responses accepted but not consumed.
  typedef struct {
    logic        w;
    logic [15:0] d;
    logic [3:0]  t;
    int          vis;
  } rsp_t;

  typedef struct {
    logic        w;
    logic [15:0] d;
    logic [3:0]  t;
    logic        p;
  } got_t;

  rsp_t        mq[$];
  got_t        got_q[$];
  logic [15:0] mem [0:31];
  int          cyc = 0;
  bit          m_pop;
  bit          m_acc;
  rsp_t        m_new;
  bit          e_valid;
  logic        e_par;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_pop = (mq.size() > 0) && (mq[0].vis <= cyc) && rsp_ready;
      m_acc = req_valid && (mq.size() < 4);
      cyc++;
      if (m_pop) mq.delete(0);
      if (m_acc) begin
        m_new.w   = req_write;
        m_new.d   = req_write ? 16'h0000 : mem[req_addr];
        m_new.t   = req_tag;
        m_new.vis = cyc + 1;
        if (req_write) mem[req_addr] = req_wdata;
        mq.push_back(m_new);
      end
    end
  end

  // Scoreboard compare on the falling edge, plus a log of consumed responses
  always @(negedge clk) begin
    n_chk++;
    if (rst) begin
      if ({req_ready, rsp_valid, busy, rsp_write, rsp_rdata, rsp_tag, rsp_parity} !== 25'd0) begin
        n_err++;
        $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b w=%b d=%h t=%h p=%b, required all zero",
                 req_ready, rsp_valid, busy, rsp_write, rsp_rdata, rsp_tag, rsp_parity);
      end
    end else begin
      e_valid = (mq.size() > 0) && (mq[0].vis <= cyc);
      if (req_ready !== (mq.size() < 4) || rsp_valid !== e_valid || busy !== (mq.size() != 0)) begin
        n_err++;
        $display("FAIL model_ctrl cyc %0d: rdy=%b vld=%b busy=%b, required rdy=%b vld=%b busy=%b",
                 cyc, req_ready, rsp_valid, busy, mq.size() < 4, e_valid, mq.size() != 0);
      end
      if (e_valid) begin
        e_par = mq[0].w ? 1'b0 : ^mq[0].d;
`ifndef DMEM_PARITY_EN
        e_par = 1'b0;
`endif
        n_chk++;
        if ({rsp_write, rsp_rdata, rsp_tag, rsp_parity} !== {mq[0].w, mq[0].d, mq[0].t, e_par}) begin
          n_err++;
          $display("FAIL model_rsp cyc %0d: w=%b d=%h t=%h p=%b, required w=%b d=%h t=%h p=%b",
                   cyc, rsp_write, rsp_rdata, rsp_tag, rsp_parity, mq[0].w, mq[0].d, mq[0].t, e_par);
        end
      end
      if (rsp_valid && rsp_ready) got_q.push_back('{rsp_write, rsp_rdata, rsp_tag, rsp_parity});
    end
  end

  // Drive one request and hold it until it is accepted (bounded)
  task automatic send(input logic w, input logic [4:0] a, input logic [15:0] d, input logic [3:0] t);
    bit acc;
    acc = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_tag = t;
    for (int b = 0; b < 200 && !acc; b++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout: request addr %0d never accepted", a);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int b = 0; b < 100 && !idle; b++) begin
      @(negedge clk); idle = !busy && (mq.size() == 0);
    end
    @(posedge clk); #1;
    n_chk++;
    if (!idle) begin
      n_err++;
      $display("FAIL drain_timeout: busy=%b model entries=%0d, required idle", busy, mq.size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    n_chk++;
    if ({req_ready, rsp_valid, busy} !== 3'b000) begin
      n_err++; $display("FAIL reset_hold: rdy/vld/busy=%b, required 000", {req_ready, rsp_valid, busy});
    end
    rst = 1'b0; #1;
    n_chk++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release: rdy=%b busy=%b, required rdy=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_write_ack();
    rsp_ready = 1'b1;
    send(1'b1, 5'd3, 16'hBEEF, 4'h1);
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL ack_early: vld=%b busy=%b, required vld=0 busy=1", rsp_valid, busy);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({rsp_valid, rsp_write, rsp_rdata, rsp_tag, busy} !== {1'b1, 1'b1, 16'h0000, 4'h1, 1'b1}) begin
      n_err++; $display("FAIL ack_rsp: vld=%b w=%b d=%h t=%h busy=%b, required 1 1 0000 1 1",
                        rsp_valid, rsp_write, rsp_rdata, rsp_tag, busy);
    end
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL ack_busy_fall: busy=%b vld=%b, required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 32; a++) begin
      if (a != 3) send(1'b1, 5'(a), 16'($urandom), 4'(a));
    end
    wait_idle();
  endtask

  task automatic test_raw_order();
    got_q.delete();
    send(1'b1, 5'd7, 16'h1234, 4'h4);
    send(1'b0, 5'd7, 16'h0000, 4'h5);
    wait_idle();
    n_chk++;
    if (got_q.size() != 2) begin
      n_err++; $display("FAIL raw_count: got %0d responses, required 2", got_q.size());
    end else if (got_q[0].w !== 1'b1 || got_q[0].t !== 4'h4 ||
                 {got_q[1].w, got_q[1].d, got_q[1].t} !== {1'b0, 16'h1234, 4'h5}) begin
      n_err++; $display("FAIL raw_data: second w=%b d=%h t=%h, required 0 1234 5",
                        got_q[1].w, got_q[1].d, got_q[1].t);
    end
  endtask

  task automatic test_backpressure();
    int k;
    bit rdy;
    logic [20:0] snap;
    got_q.delete();
    rsp_ready = 1'b0; k = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd10; req_tag = 4'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); rdy = req_ready;
      if (c == 3) snap = {rsp_write, rsp_rdata, rsp_tag};
      @(posedge clk); #1;
      if (rdy) begin k++; req_addr = 5'(10 + k); req_tag = 4'(k); end
    end
    @(negedge clk);
    n_chk++;
    if (k != 4 || req_ready !== 1'b0 || rsp_valid !== 1'b1 || {rsp_write, rsp_rdata, rsp_tag} !== snap) begin
      n_err++; $display("FAIL bp_stall: accepted=%0d rdy=%b vld=%b out=%h, required 4 0 1 %h",
                        k, req_ready, rsp_valid, {rsp_write, rsp_rdata, rsp_tag}, snap);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_no_bypass: rdy=%b on pop cycle, required 0", req_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_credit_return: rdy=%b after first pop, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();
    n_chk++;
    if (got_q.size() != 5) begin
      n_err++; $display("FAIL bp_count: got %0d responses, required 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (got_q[i].t !== 4'(i)) begin
          n_err++; $display("FAIL bp_order: slot %0d tag %h, required %h", i, got_q[i].t, 4'(i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    got_q.delete();
    send(1'b1, 5'd31, 16'hAAAA, 4'h0);
    send(1'b1, 5'd0, 16'h5555, 4'h1);
    send(1'b0, 5'd31, 16'h0000, 4'h2);
    send(1'b0, 5'd0, 16'h0000, 4'h3);
    wait_idle();
    n_chk++;
    if (got_q.size() != 4) begin
      n_err++; $display("FAIL wrap_count: got %0d responses, required 4", got_q.size());
    end else if (got_q[2].d !== 16'hAAAA || got_q[3].d !== 16'h5555) begin
      n_err++; $display("FAIL wrap_data: got %h %h, required aaaa 5555", got_q[2].d, got_q[3].d);
    end
    for (int r = 0; r < 3; r++) begin
      got_q.delete();
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(1'b0, 5'(28 + i), 16'h0000, 4'(i + 4 * r));
      repeat (3) @(posedge clk);
      #1;
      wait_idle();
      n_chk++;
      if (got_q.size() != 4) begin
        n_err++; $display("FAIL wrap_round%0d: got %0d responses, required 4", r, got_q.size());
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int c = 0; c < 400; c++) begin
      a = 5'($urandom_range(0, 31));
      req_valid = ($urandom_range(0, 9) < 7);
      req_write = ($urandom_range(0, 1) == 1) && (a != 5'd3);
      req_addr  = a;
      req_wdata = 16'($urandom);
      req_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    wait_idle();
  endtask

  task automatic test_reset_midflight();
    got_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 5'd3, 16'h0000, 4'(6 + i));
    n_chk++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_pre: busy=%b vld=%b rdy=%b, required 1 1 0", busy, rsp_valid, req_ready);
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({rsp_valid, busy, req_ready} !== 3'b000) begin
      n_err++; $display("FAIL mid_async: vld/busy/rdy=%b, required 000", {rsp_valid, busy, req_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    n_chk++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_release: rdy=%b busy=%b, required 1 0", req_ready, busy);
    end
    got_q.delete();
    rsp_ready = 1'b1;
    send(1'b0, 5'd3, 16'h0000, 4'hA);
    wait_idle();
    n_chk++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL mid_count: got %0d responses, required 1", got_q.size());
    end else if (got_q[0].d !== 16'hBEEF || got_q[0].t !== 4'hA) begin
      n_err++; $display("FAIL mid_ram_kept: d=%h t=%h, required beef a", got_q[0].d, got_q[0].t);
    end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    got_q.delete();
    send(1'b1, 5'd20, 16'h0007, 4'h1);
    send(1'b1, 5'd21, 16'h0003, 4'h2);
    send(1'b0, 5'd20, 16'h0000, 4'h3);
    send(1'b0, 5'd21, 16'h0000, 4'h4);
    wait_idle();
    n_chk++;
    if (got_q.size() != 4) begin
      n_err++; $display("FAIL par_count: got %0d responses, required 4", got_q.size());
    end else if ({got_q[0].p, got_q[1].p, got_q[2].p, got_q[3].p} !== 4'b0010) begin
      n_err++; $display("FAIL par_bits: got %b, required 0010",
                        {got_q[0].p, got_q[1].p, got_q[2].p, got_q[3].p});
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0;
    req_wdata = 16'h0000; req_tag = 4'h0; rsp_ready = 1'b0;
    test_reset();
    test_write_ack();
    test_fill();
    test_raw_order();
    test_backpressure();
    test_wrap();
    test_random();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
